// File: rtl/lc3_pkg.sv
// Shared LC-3 constants: word width and the program-loader state encoding.
package lc3_pkg;

  localparam int unsigned LC3_WORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ORIGIN = 3'd1,
    ST_COUNT  = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4
  } load_state_t;

endpackage

// File: rtl/imem_loader.sv
// Instruction RAM writer: consumes an LC-3 object image (origin, count, words),
// holds the CPU during the load and hands the origin to fetch on completion.
module imem_loader
  import lc3_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = LC3_WORD_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_WADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              CPU_HOLD,
  output logic [DATA_W-1:0] BOOT_PC,
  output logic              PC_LOAD,
  output logic              LOAD_DONE
);

  load_state_t       state, state_next;
  logic [DATA_W-1:0] origin, origin_next;
  logic [DATA_W-1:0] count, count_next;
  logic [DATA_W-1:0] index, index_next;
  logic [DATA_W-1:0] addr_sum;
  logic              xfer;
  logic              ready_next, we_next, hold_next, pc_load_next;
  logic [ADDR_W-1:0] waddr_next;
  logic [DATA_W-1:0] wdata_next, boot_pc_next;

  assign xfer     = IN_VALID && IN_READY;
  assign addr_sum = origin + index;

  // Next-state and registered-output decode
  always_comb begin
    state_next   = state;
    origin_next  = origin;
    count_next   = count;
    index_next   = index;
    we_next      = 1'b0;
    waddr_next   = MEM_WADDR;
    wdata_next   = MEM_WDATA;
    boot_pc_next = BOOT_PC;
    pc_load_next = 1'b0;

    case (state)
      ST_IDLE: begin
        if (START) state_next = ST_ORIGIN;
      end
      ST_ORIGIN: begin
        if (xfer) begin
          origin_next = IN_DATA;
          state_next  = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (xfer) begin
          count_next = IN_DATA;
          index_next = '0;
          state_next = (IN_DATA == '0) ? ST_DONE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          we_next    = 1'b1;
          waddr_next = ADDR_W'(addr_sum);
          wdata_next = IN_DATA;
          index_next = index + DATA_W'(1);
          if (index == count - DATA_W'(1)) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        boot_pc_next = origin;
        pc_load_next = 1'b1;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Ready/hold are decoded from the upcoming state so they line up with it
    ready_next = (state_next == ST_ORIGIN) || (state_next == ST_COUNT) ||
                 (state_next == ST_DATA);
    hold_next  = (state_next != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      origin    <= '0;
      count     <= '0;
      index     <= '0;
      IN_READY  <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_WADDR <= '0;
      MEM_WDATA <= '0;
      CPU_HOLD  <= 1'b0;
      BOOT_PC   <= '0;
      PC_LOAD   <= 1'b0;
      LOAD_DONE <= 1'b0;
    end else begin
      state     <= state_next;
      origin    <= origin_next;
      count     <= count_next;
      index     <= index_next;
      IN_READY  <= ready_next;
      MEM_WE    <= we_next;
      MEM_WADDR <= waddr_next;
      MEM_WDATA <= wdata_next;
      CPU_HOLD  <= hold_next;
      BOOT_PC   <= boot_pc_next;
      PC_LOAD   <= pc_load_next;
      LOAD_DONE <= pc_load_next;
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction memory: accepts a program image as a stream of 16-bit words and writes it into the instruction RAM that the fetch stage reads by PC. While loading, it holds the CPU. On completion it presents the program origin so the fetch stage can load it into PC. The image format follows the LC-3 object layout: origin word, word count, then the data words.

Parameters:
ADDR_W, 8, instruction RAM address width; write addresses are truncated to this width.
DATA_W, 16, word width of the stream and the RAM.

Ports:
CLK  input  1  system clock, rising edge.
RESET  input  1  asynchronous, active-high reset.
START  input  1  single-cycle request to begin a load; sampled only in IDLE.
IN_DATA  input  DATA_W  stream word.
IN_VALID  input  1  IN_DATA is valid.
IN_READY  output  1  loader accepts a word this cycle; transfer occurs when IN_VALID && IN_READY.
MEM_WE  output  1  instruction RAM write enable.
MEM_WADDR  output  ADDR_W  instruction RAM write address.
MEM_WDATA  output  DATA_W  instruction RAM write data.
CPU_HOLD  output  1  stall for the CPU (PC_LE/IR_LE gating); high while a load is in progress.
BOOT_PC  output  DATA_W  origin of the last completed load.
PC_LOAD  output  1  one-cycle pulse: load BOOT_PC into PC (drives Y and PC_CONTROL path).
LOAD_DONE  output  1  one-cycle pulse at completion, coincident with PC_LOAD.

Behaviour:
- Reset (async, RESET=1): state IDLE; all outputs 0; BOOT_PC=0; internal origin, count and index are 0.
- States: IDLE, ORIGIN, COUNT, DATA, DONE.
- IDLE: IN_READY=0, CPU_HOLD=0. START=1 -> ORIGIN.
- ORIGIN: IN_READY=1. On transfer, latch origin=IN_DATA -> COUNT.
- COUNT: IN_READY=1. On transfer, latch count=IN_DATA and clear index to 0. If count==0 -> DONE, else -> DATA.
- DATA: IN_READY=1. Each transfer writes one word. The write is registered: the cycle after the transfer, MEM_WE=1, MEM_WADDR=(origin+index)[ADDR_W-1:0] and MEM_WDATA=the accepted word. Index then increments.
  - Throughput is one word per cycle; IN_VALID gaps produce MEM_WE=0 cycles.
  - On the transfer with index==count-1 -> DONE.
- DONE: lasts exactly one cycle. IN_READY=0. BOOT_PC<=origin. The last data write (MEM_WE) is issued in this same cycle. Next state IDLE.
- PC_LOAD and LOAD_DONE pulse high for one cycle, the cycle after DONE. BOOT_PC is already valid in that cycle.
- CPU_HOLD is 1 in ORIGIN, COUNT, DATA and DONE. It falls in the same cycle PC_LOAD pulses, so the first fetch after the load uses the new PC.
- MEM_WE is never 1 outside the cycle after a DATA transfer.
- Address wrap: origin+index is computed at DATA_W bits and truncated to ADDR_W. Addresses wrap modulo 2^ADDR_W, with no error flag.
- Count is DATA_W bits; counts larger than 2^ADDR_W overwrite earlier words (wrap).
- START outside IDLE is ignored. IN_VALID in IDLE or DONE is not accepted (IN_READY=0).
- Reset mid-load: everything returns immediately to reset values. A pending registered write is dropped. RAM contents are undefined/partial and BOOT_PC=0.
- There is no timeout; the loader waits indefinitely for IN_VALID.

Decomposition:
- Shared package lc3_pkg: state encoding constants (IDLE=0, ORIGIN=1, COUNT=2, DATA=3, DONE=4) and the LC-3 word width constant (16).
- No sub-module: a single FSM with the origin/count/index registers and a one-stage write register. The RAM itself stays outside (dual-port: this block writes, Instruction_Fetch reads).

Test Plan:
- Basic load: START; stream 0x3000, 3, 0x1111, 0x2222, 0x3333 with IN_VALID continuous -> MEM_WE on 3 consecutive cycles at 0x00/0x01/0x02 with those data; PC_LOAD pulse with BOOT_PC=0x3000; CPU_HOLD low from that cycle.
- Backpressure gaps: same image with IN_VALID toggled 1,0,1,0 -> writes only after accepted words, addresses still consecutive; no duplicate or skipped writes.
- Zero count: 0x0040, 0 -> no MEM_WE; one cycle later PC_LOAD with BOOT_PC=0x0040.
- Wrap: ADDR_W=8, origin 0x00FE, count 4 -> MEM_WADDR sequence 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-load: assert RESET after the 2nd data word -> all outputs 0 in the same cycle; no MEM_WE for the 3rd word; a fresh load afterwards completes normally.
- START while busy and IN_VALID in IDLE: START pulsed during DATA -> no restart; IN_VALID=1 in IDLE -> IN_READY stays 0, no writes.
